dmem_write_logger: RTL

Passive responder on the processor's data-memory write port (`DM_writeEnable`, `DM_addr`, `DM_writeData`), sitting beside the processor at the top level. It captures every data-memory write into a FIFO. Each capture is tagged with a sequence number and streamed out over a valid/ready port. When `dump` is raised, the block stops capturing, drains what remains and flags completion, so benches and on-board debug logic can reconstruct the store trace.

---
 rtl/dmem_log_pkg.sv | 21 ++
 rtl/log_fifo.sv | 75 +++++++
 rtl/dmem_write_logger.sv | 123 ++++++++++++
 3 files changed

// File: rtl/dmem_log_pkg.sv
// Shared types and default sizing for the data-memory store logger.
// The packed entry layout fixes the FIFO word as {addr, data, seq}.
package dmem_log_pkg;

    localparam int LOG_N     = 64;
    localparam int LOG_DEPTH = 16;
    localparam int LOG_SEQW  = 16;

    typedef enum logic [1:0] {
        STREAM = 2'd0,
        DRAIN  = 2'd1,
        DONE   = 2'd2
    } log_state_t;

    typedef struct packed {
        logic [LOG_N-1:0]    addr;
        logic [LOG_N-1:0]    data;
        logic [LOG_SEQW-1:0] seq;
    } log_entry_t;

endpackage

// File: rtl/log_fifo.sv
// Synchronous FIFO of log entries: registered storage, combinational head.
// Push is honoured when full only if a pop happens in the same cycle.
module log_fifo
    import dmem_log_pkg::*;
#(
    parameter int DEPTH = LOG_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  log_entry_t push_entry,
    output logic       full,
    output logic       empty,
    output log_entry_t head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    log_entry_t    mem_q [DEPTH];
    logic          do_push_s;
    logic          do_pop_s;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == (AW+1)'(0));
    assign head  = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observable through a valid head
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: rtl/dmem_write_logger.sv
// Captures every data-memory store into a FIFO tagged with a sequence number
// and streams it out; dump freezes capture, drains, then flags completion.
module dmem_write_logger
    import dmem_log_pkg::*;
#(
    parameter int N     = LOG_N,
    parameter int DEPTH = LOG_DEPTH,
    parameter int SEQW  = LOG_SEQW
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic            DM_writeEnable,
    input  logic [N-1:0]    DM_addr,
    input  logic [N-1:0]    DM_writeData,
    input  logic            dump,
    output logic            log_valid,
    input  logic            log_ready,
    output logic [N-1:0]    log_addr,
    output logic [N-1:0]    log_data,
    output logic [SEQW-1:0] log_seq,
    output logic            overflow,
    output logic [SEQW-1:0] drop_count,
    output logic            dump_done
);

    log_state_t      state_q, state_d;
    logic [SEQW-1:0] seq_q, seq_d;
    logic [SEQW-1:0] drop_q, drop_d;
    logic            overflow_q, overflow_d;
    logic            done_q, done_d;

    logic            full_s;
    logic            empty_s;
    logic            pop_s;
    logic            push_s;
    logic            drop_s;
    logic            capture_s;
    log_entry_t      head_s;
    log_entry_t      new_entry_s;

    log_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (CLOCK_50),
        .reset      (reset),
        .push       (push_s),
        .pop        (pop_s),
        .push_entry (new_entry_s),
        .full       (full_s),
        .empty      (empty_s),
        .head       (head_s)
    );

    // The cycle that first samples dump is still in STREAM, so its store is kept
    assign capture_s   = (state_q == STREAM);
    assign log_valid   = !empty_s;
    assign pop_s       = log_valid && log_ready;
    assign push_s      = capture_s && DM_writeEnable && (!full_s || pop_s);
    assign drop_s      = capture_s && DM_writeEnable && full_s && !pop_s;
    assign new_entry_s = '{addr: DM_addr, data: DM_writeData, seq: seq_q};

    // Storage is not reset, so the head is masked until it holds a real entry
    assign log_addr    = log_valid ? head_s.addr : '0;
    assign log_data    = log_valid ? head_s.data : '0;
    assign log_seq     = log_valid ? head_s.seq  : '0;
    assign overflow    = overflow_q;
    assign drop_count  = drop_q;
    assign dump_done   = done_q;

    // FSM next-state, sequence and drop accounting
    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        drop_d     = drop_q;
        overflow_d = overflow_q;
        case (state_q)
            STREAM: begin
                if (dump) begin
                    state_d = DRAIN;
                end else begin
                    state_d = STREAM;
                end
            end
            DRAIN: begin
                if (empty_s && !pop_s) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = STREAM;
        endcase
        if (push_s) begin
            seq_d = seq_q + SEQW'(1);
        end else begin
            seq_d = seq_q;
        end
        if (drop_s && (drop_q != {SEQW{1'b1}})) begin
            drop_d = drop_q + SEQW'(1);
        end else begin
            drop_d = drop_q;
        end
        overflow_d = overflow_q | drop_s;
        done_d     = (state_d == DONE);
    end

    // Control registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= STREAM;
            seq_q      <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

endmodule
